// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor built from one full-adder cell
// and a carry flip-flop. Operands are processed LSB first, one bit per clock.
// Optional signed-overflow output is enabled by defining SERIAL_ADDSUB_OVF_EN.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; sum/co hold the last result
// RUN   | one operand bit per cycle through the full adder (WIDTH cycles)
// DONE  | one-cycle done pulse; start here is accepted back-to-back
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic             last_bit;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s_bit;
  logic             c_next;

  // The single full-adder cell shared by every bit position.
  always_comb begin
    s_bit  = op_a[0] ^ op_b[0] ^ carry;
    c_next = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
  end

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start is honoured in IDLE and DONE, ignored in RUN.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (last_bit) state_d = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

  // Operand capture, serial shift datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      co    <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= sub;
      cnt   <= '0;
      sum   <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (state_q == S_RUN) begin
      sum   <= {s_bit, sum[WIDTH-1:1]};
      op_a  <= {1'b0, op_a[WIDTH-1:1]};
      op_b  <= {1'b0, op_b[WIDTH-1:1]};
      carry <= c_next;
      cnt   <= cnt + CW'(1);
      if (last_bit) begin
        co  <= c_next;
`ifdef SERIAL_ADDSUB_OVF_EN
        // Signed overflow: carry into the MSB differs from carry out of it.
        ovf <= carry ^ c_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed bench for serial_addsub (WIDTH=8) with a queue
// of expected results filled at launch and drained on each done pulse.
module tb_serial_addsub;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             co;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co)
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y, logic s);
    exp_t           e;
    logic [WIDTH:0] r;
    r = {1'b0, x} + {1'b0, (s ? ~y : y)} + {{WIDTH{1'b0}}, s};
    e.sum = r[WIDTH-1:0];
    e.co  = r[WIDTH];
    if (s) e.ovf = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    else   e.ovf = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive an operation, record its expected result, let the accepting edge pass.
  task automatic launch(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s,
                        input logic hold);
    a     = x;
    b     = y;
    sub   = s;
    start = 1'b1;
    sb.push_back(model(x, y, s));
    tick();
    if (!hold) start = 1'b0;
  endtask

  // Wait (bounded) for done, check latency/busy span, then compare against the queue.
  task automatic wait_done(input string tag, input int exp_n);
    int   n;
    int   nb;
    exp_t e;
    n  = 0;
    nb = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) nb++;
      tick();
      n++;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_latency"}, n, exp_n);
    check({tag, "_busy_cycles"}, nb, exp_n);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_sb_level"}, {31'd0, (sb.size() > 0)}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_sum"}, {24'd0, sum}, {24'd0, e.sum});
      check({tag, "_co"}, {31'd0, co}, {31'd0, e.co});
`ifdef SERIAL_ADDSUB_OVF_EN
      check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e.ovf});
`endif
    end
  endtask

  task automatic pulse_end(input string tag);
    tick();
    check({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int nd;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    sub   = 1'b0;
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_co", {31'd0, co}, 32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
    check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst = 1'b0;
    tick();

    launch(8'h0F, 8'h01, 1'b0, 1'b0);
    check("add1_busy", {31'd0, busy}, 32'd1);
    wait_done("add1", WIDTH);
    pulse_end("add1");
    check("add1_hold_sum", {24'd0, sum}, 32'h10);

    launch(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done("add_wrap", WIDTH);
    pulse_end("add_wrap");

    launch(8'h7F, 8'h01, 1'b0, 1'b0);
    wait_done("add_ovf", WIDTH);
    pulse_end("add_ovf");

    launch(8'h05, 8'h07, 1'b1, 1'b0);
    wait_done("sub_neg", WIDTH);
    pulse_end("sub_neg");

    launch(8'h07, 8'h05, 1'b1, 1'b0);
    wait_done("sub_pos", WIDTH);
    pulse_end("sub_pos");

    launch(8'h80, 8'h01, 1'b1, 1'b0);
    wait_done("sub_ovf", WIDTH);
    pulse_end("sub_ovf");

    // A start while busy must not disturb the captured operands.
    launch(8'h03, 8'h04, 1'b0, 1'b0);
    tick();
    tick();
    a     = 8'hAA;
    b     = 8'h55;
    sub   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ignore", WIDTH - 3);
    pulse_end("ignore");

    // Start held high through DONE: the next operation starts back-to-back.
    launch(8'h21, 8'h13, 1'b0, 1'b1);
    wait_done("b2b_first", WIDTH);
    a   = 8'h10;
    b   = 8'h30;
    sub = 1'b1;
    sb.push_back(model(8'h10, 8'h30, 1'b1));
    tick();
    start = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_no_done", {31'd0, done}, 32'd0);
    wait_done("b2b_second", WIDTH);
    pulse_end("b2b_second");

    // Reset partway through RUN aborts the operation with no done pulse.
    launch(8'h44, 8'h22, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_sum", {24'd0, sum}, 32'd0);
    check("abort_co", {31'd0, co}, 32'd0);
    nd = 0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      if (done === 1'b1) nd++;
      tick();
    end
    check("abort_no_done", nd, 0);

    launch(8'h10, 8'h20, 1'b0, 1'b0);
    wait_done("after_abort", WIDTH);
    pulse_end("after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
